term1_result_capture: RTL and testbench
=======================================

Name: term1_result_capture

Overview:
- Downstream stage of the term1 combinational decode: registers its 10 outputs (j0..s0) each valid cycle and detects changes against the last sample.
- Queues change events in a small FIFO for a valid/ready consumer (bus bridge or trace logger).
- Converts a glitch-prone combinational vector into a clean, timestamped, lossless-unless-full event stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp width in bits
- CNT_W, 8, overflow counter width in bits

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush
- in_valid  input  1  in_result is meaningful this cycle
- in_result  input  10  term1 outputs; bit0=j0, bit1=k0 … bit9=s0
- out_valid  output  1  FIFO head entry available
- out_ready  input  1  consumer accepts head entry
- out_result  output  10  head entry result vector
- out_diff  output  10  head entry changed-bit mask
- out_ts  output  TS_W  head entry timestamp; 0 when feature disabled
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- ovf_cnt  output  CNT_W  saturating count of dropped events

Behaviour:
- Reset (rst_n low, async): FIFO empty, out_valid=0, level=0, ovf_cnt=0. out_result, out_diff and out_ts = 0. Baseline = 0. FSM = NOBASE. Timestamp = 0.
- FSM states:
  - NOBASE: waiting for first sample. First in_valid loads baseline, enqueues {in_result, diff=10'h3FF}, then goes to TRACK.
  - TRACK: on in_valid, diff = in_result ^ baseline. Enqueue only if diff != 0. Baseline takes in_result on every in_valid, whether or not the push succeeds.
- Enqueue happens at the sampling edge. With an empty FIFO, out_valid rises the next cycle (1-cycle latency). Output fields come straight from registered FIFO storage, never combinationally from in_result.
- Pop: out_valid & out_ready at a rising edge removes the head entry. Outputs are stable while out_valid=1 and out_ready=0.
- Full (level==DEPTH) with push and no pop: event dropped, ovf_cnt += 1, saturating at all-ones.
- Full with push and pop in the same cycle: both succeed; level unchanged, no drop.
- Empty with push and pop in the same cycle: pop ignored (out_valid=0); push succeeds.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the authoritative full/empty indicator.
- clear has priority over push and pop. It empties the FIFO, zeroes ovf_cnt, returns to NOBASE and ignores that cycle's sample. The timestamp is not cleared.
- Reset mid-transfer discards all entries. No output handshake is pending after reset.

Optional Feature:
- TERM1_CAPTURE_TIMESTAMP_EN defined:
  - Free-running TS_W-bit counter, starting at 0 after reset, wrapping modulo 2^TS_W.
  - Each entry stores the counter value at its sampling edge; out_ts presents it.
- Not defined: no counter or timestamp storage; out_ts tied to 0.

Decomposition:
- Shared package term1_pkg:
  - RES_W=10 and the bit-index constants J0..S0.
  - Capture FSM state enum {NOBASE, TRACK}.
  - Packed entry struct {result, diff, ts}.
- One sub-module: term1_evt_fifo, a synchronous FIFO parameterised on DEPTH and entry width, with push/pop/clear/level/full/empty. The top holds the FSM, baseline, diff logic and overflow counter.

Test Plan:
- Reset, then in_valid with in_result=10'h001 -> next cycle out_valid=1, out_result=10'h001, out_diff=10'h3FF.
- Then in_valid with 10'h001 twice, then 10'h005 -> exactly one new entry, out_result=10'h005, out_diff=10'h004.
- Hold out_ready=0; push DEPTH+3 distinct changes after the first -> level=8, ovf_cnt=3 (DEPTH=8). Raise out_ready -> entries drain in order with no gaps.
- FIFO full with push and pop in the same cycle -> level stays 8, ovf_cnt unchanged, popped entry is the oldest.
- Assert clear with 5 entries queued and in_valid=1 -> next cycle level=0, out_valid=0, ovf_cnt=0. The following sample is treated as first (diff=10'h3FF).
- With TERM1_CAPTURE_TIMESTAMP_EN, samples at cycles 10 and 13 after reset -> out_ts=10 then 13. Without the macro, out_ts=0 throughout.

Source files
------------

// File: rtl/term1_pkg.sv
// term1_pkg: shared widths, bit indices, capture states and event layout for term1 result capture
package term1_pkg;
  localparam int RES_W = 10;
  localparam int J0 = 0;
  localparam int K0 = 1;
  localparam int L0 = 2;
  localparam int M0 = 3;
  localparam int N0 = 4;
  localparam int O0 = 5;
  localparam int P0 = 6;
  localparam int Q0 = 7;
  localparam int R0 = 8;
  localparam int S0 = 9;
  typedef logic [RES_W-1:0] res_t;
  typedef enum logic {NOBASE, TRACK} cap_state_t;
  typedef struct packed {
    res_t result;
    res_t diff;
  } evt_t;
  function automatic res_t diff_of(input cap_state_t st, input res_t cur, input res_t base);
    return st == NOBASE ? '1 : cur ^ base;
  endfunction
endpackage

// File: rtl/term1_evt_fifo.sv
// term1_evt_fifo: synchronous FIFO with registered storage, occupancy level and flush
module term1_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == FULL_LVL;
  assign do_pop = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);
  assign dout = empty ? '0 : mem[rp];
  // pointer and occupancy bookkeeping; flush returns to empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // entry storage; contents only visible while occupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/term1_result_capture.sv
// term1_result_capture: registers term1 outputs, queues change events (timestamps via TERM1_CAPTURE_TIMESTAMP_EN)
module term1_result_capture
  import term1_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [RES_W-1:0]       in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_result,
  output logic [RES_W-1:0]       out_diff,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       ovf_cnt
);
  cap_state_t state, state_n;
  res_t base, diff;
  logic sample, push, drop, full, empty;
  evt_t evt, head;
  assign sample = in_valid & ~clear;
  assign diff = diff_of(state, in_result, base);
  assign push = sample & (|diff);
  assign drop = push & full & ~out_ready;
  assign evt = '{result: in_result, diff: diff};
`ifdef TERM1_CAPTURE_TIMESTAMP_EN
  localparam int EW = 2*RES_W + TS_W;
  logic [TS_W-1:0] ts;
  logic [EW-1:0] din, dout;
  // free-running timestamp, untouched by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else ts <= ts + 1'b1;
  end
  assign din = {evt, ts};
  assign head = dout[EW-1:TS_W];
  assign out_ts = dout[TS_W-1:0];
`else
  localparam int EW = 2*RES_W;
  logic [EW-1:0] din, dout;
  assign din = evt;
  assign head = dout;
  assign out_ts = '0;
`endif
  assign out_valid = ~empty;
  assign out_result = head.result;
  assign out_diff = head.diff;
  // capture state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOBASE;
    else state <= state_n;
  end
  // first sample after reset/clear establishes the baseline
  always_comb begin
    state_n = state;
    state_n = clear ? NOBASE : (in_valid ? TRACK : state);
  end
  // baseline follows every accepted sample, pushed or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base <= '0;
    else if (sample) base <= in_result;
  end
  // saturating count of events lost to a full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt <= '0;
    else if (clear) ovf_cnt <= '0;
    else if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
  end
  term1_evt_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(push),
    .pop(out_ready),
    .din(din),
    .dout(dout),
    .level(level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_term1_result_capture.sv
// tb_term1_result_capture: directed vector table plus queue-model sequences for term1_result_capture
module tb_term1_result_capture;
  localparam int DEPTH = 8;
  localparam int TS_W = 16;
  localparam int CNT_W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [9:0] in_result = '0;
  logic out_valid;
  logic [9:0] out_result, out_diff;
  logic [TS_W-1:0] out_ts;
  logic [3:0] level;
  logic [CNT_W-1:0] ovf_cnt;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  typedef struct {
    logic v;
    logic [9:0] r;
    logic rdy;
    logic ev;
    logic [9:0] er;
    logic [9:0] ed;
    int lvl;
    int ovf;
    int head;
  } vec_t;
  typedef struct {
    logic [9:0] r;
    logic [9:0] d;
    int t;
  } ent_t;
  vec_t tbl[5];
  int samp_cyc[5];
  ent_t q[$];
  logic [9:0] base;
  bit have_base;
  int m_ovf;

  term1_result_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_result(in_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_diff(out_diff),
    .out_ts(out_ts),
    .level(level),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ts_x(input int c);
`ifdef TERM1_CAPTURE_TIMESTAMP_EN
    return 32'(c % (1 << TS_W));
`else
    return 32'(c - c);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_head(input string nm);
    if (q.size() == 0) begin
      chk({nm, ".valid"}, 32'(out_valid), 0);
    end else begin
      chk({nm, ".valid"}, 32'(out_valid), 1);
      chk({nm, ".result"}, 32'(out_result), 32'(q[0].r));
      chk({nm, ".diff"}, 32'(out_diff), 32'(q[0].d));
      chk({nm, ".ts"}, 32'(out_ts), ts_x(q[0].t));
    end
    chk({nm, ".level"}, 32'(level), 32'(q.size()));
    chk({nm, ".ovf"}, 32'(ovf_cnt), 32'(m_ovf));
  endtask

  task automatic send(input logic [9:0] val, input string nm);
    logic [9:0] d;
    in_valid = 1'b1;
    in_result = val;
    d = have_base ? (val ^ base) : 10'h3FF;
    if (d != 0) begin
      if (q.size() < DEPTH) q.push_back('{val, d, cyc});
      else if (m_ovf < 255) m_ovf++;
    end
    base = val;
    have_base = 1'b1;
    step();
    in_valid = 1'b0;
    chk({nm, ".level"}, 32'(level), 32'(q.size()));
    chk({nm, ".ovf"}, 32'(ovf_cnt), 32'(m_ovf));
  endtask

  task automatic do_clear(input string nm);
    clear = 1'b1;
    in_valid = 1'b1;
    in_result = 10'h2C3;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_ovf = 0;
    have_base = 1'b0;
    chk({nm, ".level"}, 32'(level), 0);
    chk({nm, ".valid"}, 32'(out_valid), 0);
    chk({nm, ".ovf"}, 32'(ovf_cnt), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h001, 1'b1, 1'b1, 10'h001, 10'h3FF, 1, 0, 0};
    tbl[1] = '{1'b1, 10'h001, 1'b0, 1'b1, 10'h001, 10'h3FF, 1, 0, 0};
    tbl[2] = '{1'b1, 10'h001, 1'b0, 1'b1, 10'h001, 10'h3FF, 1, 0, 0};
    tbl[3] = '{1'b1, 10'h005, 1'b1, 1'b1, 10'h005, 10'h004, 1, 0, 3};
    tbl[4] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h000, 0, 0, -1};
    #2;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.ovf", 32'(ovf_cnt), 0);
    chk("rst.result", 32'(out_result), 0);
    chk("rst.diff", 32'(out_diff), 0);
    chk("rst.ts", 32'(out_ts), 0);
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = tbl[i].v;
      in_result = tbl[i].r;
      out_ready = tbl[i].rdy;
      samp_cyc[i] = cyc;
      step();
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.result", i), 32'(out_result), 32'(tbl[i].er));
      chk($sformatf("vec%0d.diff", i), 32'(out_diff), 32'(tbl[i].ed));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf_cnt), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d.ts", i), 32'(out_ts), tbl[i].head < 0 ? 0 : ts_x(samp_cyc[tbl[i].head]));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    base = 10'h005;
    have_base = 1'b1;
    m_ovf = 0;
    for (int i = 0; i < DEPTH + 3; i++) send(10'h100 + 10'(i), $sformatf("fill%0d", i));
    chk("fill.level8", 32'(level), 8);
    chk("fill.ovf3", 32'(ovf_cnt), 3);
    chk_head("fill.head");
    out_ready = 1'b1;
    void'(q.pop_front());
    send(10'h2AA, "fullpp");
    chk_head("fullpp.head");
    for (int i = 0; i < DEPTH; i++) begin
      chk_head($sformatf("drain%0d", i));
      step();
      void'(q.pop_front());
    end
    chk_head("drained");
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 260; i++) send(i[0] ? 10'h0F0 : 10'h00F, "sat");
    chk("sat.ovf", 32'(ovf_cnt), 255);
    do_clear("clr_full");
    send(10'h155, "first");
    chk_head("first.head");
    for (int i = 0; i < 4; i++) send(10'h156 + 10'(i), "five");
    chk("five.level", 32'(level), 5);
    do_clear("clr5");
    send(10'h155, "refirst");
    chk_head("refirst.head");
    send(10'h0AA, "pre_rst");
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 0);
    chk("midrst.level", 32'(level), 0);
    chk("midrst.result", 32'(out_result), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
